axi_xbar_map_ctrl: RTL and testbench

// - Runtime controller for the crossbar address map (addr_map_i of the xbar top).
// - Holds a shadow rule table, programmed over a 32-bit register port.
// - On commit it blocks new AW/AR at the xbar slave ports and waits for outstanding transactions to drain.
// - It then swaps the shadow table into the active map in one cycle, so the decode never changes mid-transaction.

---
 rtl/axi_xbar_map_ctrl.sv | 179 +++++++++++++++++
 tb/tb_axi_xbar_map_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_xbar_map_ctrl.sv
// Runtime controller for the crossbar address map: shadow rule table, drain-then-swap commit.
// Optional drain timeout is enabled by defining AXI_XBAR_MAP_CTRL_TIMEOUT_EN.
module axi_xbar_map_ctrl #(
    parameter int unsigned NoSlvPorts    = 4,
    parameter int unsigned NoAddrRules   = 4,
    parameter int unsigned CntWidth      = 8,
    parameter int unsigned TimeoutCycles = 1024,
    // Rule packing matches axi_pkg::xbar_rule_64_t: {idx[31:0], start_addr[63:0], end_addr[63:0]}
    parameter logic [NoAddrRules-1:0][159:0] DefaultMap = '0
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            cfg_req_i,
    input  logic                            cfg_we_i,
    input  logic [11:0]                     cfg_addr_i,
    input  logic [31:0]                     cfg_wdata_i,
    output logic                            cfg_gnt_o,
    output logic                            cfg_rvalid_o,
    output logic [31:0]                     cfg_rdata_o,
    input  logic [NoSlvPorts-1:0]           aw_hs_i,
    input  logic [NoSlvPorts-1:0]           ar_hs_i,
    input  logic [NoSlvPorts-1:0]           b_hs_i,
    input  logic [NoSlvPorts-1:0]           r_last_hs_i,
    output logic                            block_o,
    output logic                            busy_o,
    output logic [NoAddrRules-1:0][159:0]   addr_map_o
);

    typedef enum logic [1:0] {StIdle, StDrain, StSwap} state_e;

    localparam int unsigned SelW = (NoAddrRules > 1) ? $clog2(NoAddrRules) : 1;
    localparam int unsigned SumW = CntWidth + 2 * NoSlvPorts;

    state_e                        r_state, w_state_d;
    logic                          r_block, r_rvalid;
    logic [31:0]                   r_rdata, w_rdata;
    logic [CntWidth-1:0]           r_cnt, w_cnt_d;
    logic [NoAddrRules-1:0][159:0] r_shadow, r_map;
    logic [9:0]                    w_off;
    logic                          w_rd, w_wr, w_commit, w_rule_hit, w_timeout_err;
    logic [SelW-1:0]               w_rule_sel;
    logic [7:0]                    w_rule_lsb;
    logic [SumW-1:0]               w_inc, w_dec;
    logic signed [SumW-1:0]        w_sum;
    logic                          w_underflow, w_overflow;

`ifdef AXI_XBAR_MAP_CTRL_TIMEOUT_EN
    localparam int unsigned TimeoutW = $clog2(TimeoutCycles + 1);
    logic [TimeoutW-1:0] r_to_cnt;
    logic                r_timeout_err, w_timeout;
`endif

    assign w_off     = cfg_addr_i[11:2];
    assign cfg_gnt_o = cfg_req_i & (~cfg_we_i | (r_state == StIdle));
    assign w_rd      = cfg_gnt_o & ~cfg_we_i;
    assign w_wr      = cfg_gnt_o & cfg_we_i;
    assign w_commit  = w_wr & (w_off == 10'd0) & cfg_wdata_i[0];

    // Rule words: word 8+8r holds idx, then start_lo, start_hi, end_lo, end_hi.
    always_comb begin
        w_rule_hit = 1'b0;
        w_rule_sel = '0;
        for (int r = 0; r < NoAddrRules; r++) begin
            if (w_off[9:3] == 7'(r + 1) && w_off[2:0] < 3'd5) begin
                w_rule_hit = 1'b1;
                w_rule_sel = SelW'(r);
            end
        end
        case (w_off[2:0])
            3'd0:    w_rule_lsb = 8'd128;
            3'd1:    w_rule_lsb = 8'd64;
            3'd2:    w_rule_lsb = 8'd96;
            3'd4:    w_rule_lsb = 8'd32;
            default: w_rule_lsb = 8'd0;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        if (w_rule_hit) begin
            w_rdata = r_shadow[w_rule_sel][w_rule_lsb +: 32];
        end else if (w_off == 10'd1) begin
            w_rdata = {30'd0, w_timeout_err, busy_o};
        end else if (w_off == 10'd2) begin
            w_rdata = 32'(r_cnt);
        end
    end

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int p = 0; p < NoSlvPorts; p++) begin
            w_inc = w_inc + SumW'(aw_hs_i[p] | ar_hs_i[p]);
            w_dec = w_dec + SumW'(b_hs_i[p] | r_last_hs_i[p]);
        end
        w_sum       = $signed(SumW'(r_cnt)) + $signed(w_inc) - $signed(w_dec);
        w_underflow = w_sum[SumW-1];
        w_overflow  = w_sum > $signed(SumW'({CntWidth{1'b1}}));
        w_cnt_d     = w_underflow ? '0 : (w_overflow ? '1 : w_sum[CntWidth-1:0]);
    end

    always_comb begin
        w_state_d = r_state;
`ifdef AXI_XBAR_MAP_CTRL_TIMEOUT_EN
        w_timeout = 1'b0;
`endif
        case (r_state)
            StIdle: if (w_commit) w_state_d = StDrain;
            StDrain: begin
                if (r_block && r_cnt == '0) begin
                    w_state_d = StSwap;
`ifdef AXI_XBAR_MAP_CTRL_TIMEOUT_EN
                end else if (r_to_cnt == TimeoutW'(TimeoutCycles - 1)) begin
                    w_state_d = StIdle;
                    w_timeout = 1'b1;
`endif
                end
            end
            StSwap:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= StIdle;
            r_block  <= 1'b0;
            r_cnt    <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_shadow <= DefaultMap;
            r_map    <= DefaultMap;
        end else begin
            r_state  <= w_state_d;
            // Block stays up through SWAP so no AW/AR sees a half-updated map.
            r_block  <= (w_state_d != StIdle);
            r_cnt    <= w_cnt_d;
            r_rvalid <= w_rd;
            if (w_rd) r_rdata <= w_rdata;
            if (w_wr && w_rule_hit) r_shadow[w_rule_sel][w_rule_lsb +: 32] <= cfg_wdata_i;
            if (r_state == StSwap) r_map <= r_shadow;
        end
    end

`ifdef AXI_XBAR_MAP_CTRL_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_to_cnt <= (r_state == StDrain) ? r_to_cnt + 1'b1 : '0;
            if (w_commit) begin
                r_timeout_err <= 1'b0;
            end else if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end
    assign w_timeout_err = r_timeout_err;
`else
    assign w_timeout_err = 1'b0;
`endif

    assign block_o      = r_block;
    assign busy_o       = (r_state != StIdle);
    assign cfg_rvalid_o = r_rvalid;
    assign cfg_rdata_o  = r_rdata;
    assign addr_map_o   = r_map;

`ifndef SYNTHESIS
    a_cnt_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !w_underflow);
    a_cnt_overflow:  assert property (@(posedge clk_i) disable iff (rst_i) !w_overflow);
    a_addr_aligned:  assert property (@(posedge clk_i) disable iff (rst_i)
                                      cfg_req_i |-> cfg_addr_i[1:0] == 2'b00);
    a_params:        assert property (@(posedge clk_i)
                                      NoAddrRules >= 1 && NoAddrRules <= 16 && TimeoutCycles >= 1);
`endif

endmodule

// File: tb/tb_axi_xbar_map_ctrl.sv
// Self-checking bench for axi_xbar_map_ctrl: register reads go through a scoreboard queue,
// state/map observations are checked directly.
module tb_axi_xbar_map_ctrl;

    localparam int unsigned NP = 4;
    localparam int unsigned NR = 4;
    localparam logic [159:0] R1 = {32'd2, 64'h0000_0000_8000_0000, 64'h0000_0000_9000_0000};
    localparam logic [159:0] R0 = {32'd1, 64'h0000_0000_0000_1000, 64'h0000_0000_0000_2000};

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 req = 1'b0, we = 1'b0;
    logic [11:0]          addr = '0;
    logic [31:0]          wdata = '0;
    logic                 gnt, rvalid;
    logic [31:0]          rdata;
    logic [NP-1:0]        aw_hs = '0, ar_hs = '0, b_hs = '0, r_hs = '0;
    logic                 block, busy;
    logic [NR-1:0][159:0] map;

    int unsigned   n_vec = 0;
    int unsigned   n_err = 0;
    logic [31:0]   sb_data[$];
    string         sb_tag[$];

    always #5 clk = ~clk;

    axi_xbar_map_ctrl #(
        .NoSlvPorts    (NP),
        .NoAddrRules   (NR),
        .CntWidth      (8),
        .TimeoutCycles (16)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_req_i    (req),
        .cfg_we_i     (we),
        .cfg_addr_i   (addr),
        .cfg_wdata_i  (wdata),
        .cfg_gnt_o    (gnt),
        .cfg_rvalid_o (rvalid),
        .cfg_rdata_o  (rdata),
        .aw_hs_i      (aw_hs),
        .ar_hs_i      (ar_hs),
        .b_hs_i       (b_hs),
        .r_last_hs_i  (r_hs),
        .block_o      (block),
        .busy_o       (busy),
        .addr_map_o   (map)
    );

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [11:0] a, input logic [31:0] d, input logic exp_gnt,
                             input string tag);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        check({tag, "_gnt"}, gnt, exp_gnt);
        tick();
        req = 1'b0; we = 1'b0;
    endtask

    task automatic cfg_read(input logic [11:0] a, input logic [31:0] exp, input string tag);
        sb_data.push_back(exp);
        sb_tag.push_back(tag);
        req = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        check({tag, "_gnt"}, gnt, 1'b1);
        tick();
        req = 1'b0;
    endtask

    task automatic pulse(input logic [NP-1:0] aw, input logic [NP-1:0] ar,
                         input logic [NP-1:0] b, input logic [NP-1:0] r);
        aw_hs = aw; ar_hs = ar; b_hs = b; r_hs = r;
        tick();
        aw_hs = '0; ar_hs = '0; b_hs = '0; r_hs = '0;
    endtask

    task automatic check_ctl(input string tag, input logic exp_busy, input logic exp_block);
        check({tag, "_busy"}, busy, exp_busy);
        check({tag, "_block"}, block, exp_block);
    endtask

    always @(negedge clk) begin
        if (!rst && rvalid) begin
            if (sb_data.size() == 0) begin
                check("rvalid_unexpected", rvalid, 1'b0);
            end else begin
                check(sb_tag.pop_front(), rdata, sb_data.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_ctl("in_reset", 1'b0, 1'b0);
        rst = 1'b0;
        check_ctl("after_reset", 1'b0, 1'b0);
        for (int r = 0; r < NR; r++) check($sformatf("rst_map%0d", r), map[r], '0);
        cfg_read(12'h004, 32'h0, "rst_status");
        cfg_read(12'h008, 32'h0, "rst_outstanding");

        // Program rule1 and commit on an idle bus
        cfg_write(12'h040, 32'd2,          1'b1, "r1_idx");
        cfg_write(12'h044, 32'h8000_0000, 1'b1, "r1_slo");
        cfg_write(12'h048, 32'h0,          1'b1, "r1_shi");
        cfg_write(12'h04C, 32'h9000_0000, 1'b1, "r1_elo");
        cfg_write(12'h050, 32'h0,          1'b1, "r1_ehi");
        cfg_read(12'h040, 32'd2,          "r1_idx_rb");
        cfg_read(12'h044, 32'h8000_0000, "r1_slo_rb");
        cfg_read(12'h04C, 32'h9000_0000, "r1_elo_rb");
        cfg_write(12'h054, 32'hDEAD_BEEF, 1'b1, "unmapped_wr");
        cfg_read(12'h054, 32'h0, "unmapped_rd");
        cfg_write(12'h0A0, 32'hCAFE_F00D, 1'b1, "oor_wr");
        cfg_read(12'h0A0, 32'h0, "oor_rd");
        cfg_read(12'h000, 32'h0, "ctrl_rd");
        check("pre_commit_map1", map[1], '0);

        cfg_write(12'h000, 32'h1, 1'b1, "commit1");
        check_ctl("c1_cyc1", 1'b1, 1'b1);
        check("c1_cyc1_map1", map[1], '0);
        tick();
        check_ctl("c1_cyc2", 1'b1, 1'b1);
        check("c1_cyc2_map1", map[1], '0);
        tick();
        check_ctl("c1_cyc3", 1'b0, 1'b0);
        check("c1_cyc3_map1", map[1], R1);
        cfg_read(12'h008, 32'h0, "c1_outstanding");

        // Same-cycle increment and decrement net out
        pulse(4'b0011, 4'b0000, 4'b0001, 4'b0000);
        cfg_read(12'h008, 32'd1, "cnt_net");
        pulse(4'b0000, 4'b0000, 4'b0001, 4'b0000);
        cfg_read(12'h008, 32'd0, "cnt_back0");

        // Commit with 3 AW + 2 AR outstanding
        cfg_write(12'h020, 32'd1,     1'b1, "r0_idx");
        cfg_write(12'h024, 32'h1000, 1'b1, "r0_slo");
        cfg_write(12'h02C, 32'h2000, 1'b1, "r0_elo");
        pulse(4'b0111, 4'b0000, 4'b0000, 4'b0000);
        pulse(4'b0000, 4'b0011, 4'b0000, 4'b0000);
        cfg_read(12'h008, 32'd5, "cnt5");
        cfg_write(12'h000, 32'h1, 1'b1, "commit2");
        check_ctl("c2_cyc1", 1'b1, 1'b1);
        pulse(4'b0000, 4'b0000, 4'b0111, 4'b0000);
        check_ctl("c2_cyc2", 1'b1, 1'b1);
        cfg_read(12'h004, 32'h1, "c2_status_busy");
        cfg_write(12'h060, 32'h55, 1'b0, "drain_wr");
        cfg_read(12'h008, 32'd2, "c2_cnt2");
        check_ctl("c2_cyc5", 1'b1, 1'b1);
        pulse(4'b0000, 4'b0000, 4'b0000, 4'b0011);
        check_ctl("c2_cnt0", 1'b1, 1'b1);
        check("c2_cnt0_map0", map[0], '0);
        tick();
        check_ctl("c2_swap", 1'b1, 1'b1);
        check("c2_swap_map0", map[0], '0);
        tick();
        check_ctl("c2_done", 1'b0, 1'b0);
        check("c2_done_map0", map[0], R0);
        check("c2_done_map1", map[1], R1);
        check("c2_done_map2", map[2], '0);
        cfg_read(12'h060, 32'h0, "r2_idx_unchanged");

`ifdef AXI_XBAR_MAP_CTRL_TIMEOUT_EN
        // One AW never completes: commit gives up after 16 DRAIN cycles
        cfg_write(12'h060, 32'h9, 1'b1, "to_r2_idx");
        pulse(4'b0001, 4'b0000, 4'b0000, 4'b0000);
        cfg_write(12'h000, 32'h1, 1'b1, "commit_to");
        for (int i = 1; i <= 16; i++) check_ctl($sformatf("to_cyc%0d", i), 1'b1, 1'b1);
        for (int i = 1; i <= 16; i++) tick();
        check_ctl("to_idle", 1'b0, 1'b0);
        check("to_map2", map[2], '0);
        cfg_read(12'h004, 32'h2, "to_status");
        pulse(4'b0000, 4'b0000, 4'b0001, 4'b0000);
`endif

        // Reset mid-DRAIN abandons the commit and the shadow edits
        pulse(4'b0001, 4'b0000, 4'b0000, 4'b0000);
        cfg_write(12'h080, 32'h7, 1'b1, "r3_idx");
        cfg_write(12'h000, 32'h1, 1'b1, "commit3");
        tick();
        check_ctl("c3_drain", 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_ctl("mid_reset", 1'b0, 1'b0);
        for (int r = 0; r < NR; r++) check($sformatf("mid_reset_map%0d", r), map[r], '0);
        tick();
        rst = 1'b0;
        cfg_read(12'h080, 32'h0, "r3_idx_lost");
        cfg_read(12'h040, 32'h0, "r1_idx_lost");
        cfg_read(12'h008, 32'h0, "post_rst_cnt");
        cfg_read(12'h004, 32'h0, "post_rst_status");
        tick();
        check("sb_drained", 160'(sb_data.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
